// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: shared FSM state encoding and time-field moduli for the stopwatch.
//   STOP/RUN/CLEAR  run-control FSM states
//   MSEC_MOD        centisecond modulus (0..99)
//   SEC_MOD         second modulus (0..59)
//   MIN_MOD         minute modulus (0..59)
package stopwatch_ctrl_pkg;
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;
    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
endpackage

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: wrap-around modulo-MOD counter stage of the time cascade.
//   clk, rst   clock and synchronous active-high reset
//   i_tick     advance by one this cycle
//   i_clear    synchronous zero (takes priority over i_tick)
//   o_value    registered count, 0..MOD-1
//   o_carry    combinational: i_tick while at MOD-1, advances the next stage in the same cycle
module stopwatch_time_counter #(
    parameter int MOD   = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            o_value <= '0;
        else if (i_tick)
            o_value <= (o_value == LAST) ? '0 : o_value + WIDTH'(1);
    end

    assign o_carry = i_tick & (o_value == LAST);
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear FSM, 10 ms tick generator and hh:mm:ss.cc counter cascade.
//   clk, rst     clock and synchronous active-high reset
//   i_btn_run    one-cycle run/stop toggle pulse
//   i_btn_clear  one-cycle clear pulse (honoured only in STOP)
//   o_msec       centiseconds 0..99
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_hour       hours 0..HOUR_MAX-1
//   o_running    high while in RUN
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_COUNT = 1_000_000,
    parameter int HOUR_MAX   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_running
);
    localparam int TW = $clog2(TICK_COUNT);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick, clear;
    logic          c_msec, c_sec, c_min, unused_day_carry;

    assign clear = (state == CLEAR);
    assign tick  = (state == RUN) && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STOP;
            o_running <= 1'b0;
        end else begin
            case (state)
                STOP: begin
                    state     <= i_btn_clear ? CLEAR : (i_btn_run ? RUN : STOP);
                    o_running <= !i_btn_clear && i_btn_run;
                end
                RUN: begin
                    state     <= i_btn_run ? STOP : RUN;
                    o_running <= !i_btn_run;
                end
                default: begin
                    state     <= STOP;
                    o_running <= 1'b0;
                end
            endcase
        end
    end

    // Holds its value outside RUN so a pause resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst || clear)
            tick_cnt <= '0;
        else if (state == RUN)
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    stopwatch_time_counter #(.MOD(MSEC_MOD), .WIDTH(7)) u_msec (
        .clk(clk), .rst(rst), .i_tick(tick), .i_clear(clear), .o_value(o_msec), .o_carry(c_msec)
    );
    stopwatch_time_counter #(.MOD(SEC_MOD), .WIDTH(6)) u_sec (
        .clk(clk), .rst(rst), .i_tick(c_msec), .i_clear(clear), .o_value(o_sec), .o_carry(c_sec)
    );
    stopwatch_time_counter #(.MOD(MIN_MOD), .WIDTH(6)) u_min (
        .clk(clk), .rst(rst), .i_tick(c_sec), .i_clear(clear), .o_value(o_min), .o_carry(c_min)
    );
    stopwatch_time_counter #(.MOD(HOUR_MAX), .WIDTH(5)) u_hour (
        .clk(clk), .rst(rst), .i_tick(c_min), .i_clear(clear), .o_value(o_hour),
        .o_carry(unused_day_carry)
    );
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench comparing the stopwatch against an elapsed-time model.
module tb_stopwatch_ctrl;
    localparam int TICK = 4;
    localparam int HMAX = 24;
    localparam int DAY  = HMAX * 360000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_clear = 1'b0;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       running;

    stopwatch_ctrl #(.TICK_COUNT(TICK), .HOUR_MAX(HMAX)) dut (
        .clk(clk), .rst(rst), .i_btn_run(btn_run), .i_btn_clear(btn_clear),
        .o_msec(msec), .o_sec(sec), .o_min(min), .o_hour(hour), .o_running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ms;
        int s;
        int m;
        int h;
        int run;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: control mode, cycles into the current centisecond, total elapsed centiseconds.
    localparam int M_STOP = 0, M_RUN = 1, M_CLEAR = 2;
    int mode = M_STOP;
    int phase = 0;
    int total = 0;

    function automatic void model(input logic r, input logic c, input logic x);
        exp_t e;
        int   prev;
        if (x) begin
            mode = M_STOP;
            phase = 0;
            total = 0;
        end else begin
            prev = mode;
            if (prev == M_RUN) begin
                phase = phase + 1;
                if (phase == TICK) begin
                    phase = 0;
                    total = (total + 1) % DAY;
                end
            end
            if (prev == M_CLEAR) begin
                phase = 0;
                total = 0;
            end
            if (prev == M_STOP) mode = c ? M_CLEAR : (r ? M_RUN : M_STOP);
            else if (prev == M_RUN) mode = r ? M_STOP : M_RUN;
            else mode = M_STOP;
        end
        e.ms  = total % 100;
        e.s   = (total / 100) % 60;
        e.m   = (total / 6000) % 60;
        e.h   = total / 360000;
        e.run = (mode == M_RUN) ? 1 : 0;
        q.push_back(e);
    endfunction

    task automatic step(input logic r, input logic c, input logic x);
        @(negedge clk);
        btn_run = r;
        btn_clear = c;
        rst = x;
        model(r, c, x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Deposits 23:59:59.98 into the stopped counters; the registers keep it after release.
    task automatic preset_near_day_end();
        @(negedge clk);
        btn_run = 1'b0;
        btn_clear = 1'b0;
        rst = 1'b0;
        force dut.u_msec.o_value = 7'd98;
        force dut.u_sec.o_value = 6'd59;
        force dut.u_min.o_value = 6'd59;
        force dut.u_hour.o_value = 5'd23;
        #1;
        release dut.u_msec.o_value;
        release dut.u_sec.o_value;
        release dut.u_min.o_value;
        release dut.u_hour.o_value;
        total = DAY - 2;
        model(1'b0, 1'b0, 1'b0);
    endtask

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("msec", int'(msec), e.ms);
                chk("sec", int'(sec), e.s);
                chk("min", int'(min), e.m);
                chk("hour", int'(hour), e.h);
                chk("running", int'(running), e.run);
            end
        end
    end

    initial begin : stimulus
        // reset held, then no counting without a run pulse
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(10);
        // run through the first seconds carry
        step(1'b1, 1'b0, 1'b0);
        idle(404);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        // pause holds time and tick phase
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        idle(100);
        step(1'b1, 1'b0, 1'b0);
        idle(6);
        // clear ignored in RUN; clear beats run in STOP
        step(1'b0, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        // full day rollover on one tick
        preset_near_day_end();
        step(1'b1, 1'b0, 1'b0);
        idle(10);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        // reset mid-run
        step(1'b1, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(5);
        // random pulses
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 499) == 0));
        idle(2);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
